seg7_reader: RTL and testbench

Reconstructs digit codes by watching a multiplexed, active-high 7-segment display bus (segment lines plus one-hot digit enables) and inverting the BCD/glyph-to-segment mapping back to 4-bit codes. It is the receive end of our segment drivers: it sits beside a display or board-to-board link, debounces each digit's dwell, and hands complete frames to downstream logic through a valid/ready handshake. Typical use is self-check of our own display output and reading another board's display.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg7_reader.sv | 149 ++++++++++++++
 tb/tb_seg7_reader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment reader: segment patterns (bit 0 = a .. bit 6 = g),
// the 4-bit codes they decode to, and the dwell-tracking state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_U     = 7'b0111110;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_U       = 4'd10;
  localparam logic [3:0] CODE_P       = 4'd11;
  localparam logic [3:0] CODE_L       = 4'd12;
  localparam logic [3:0] CODE_ILLEGAL = 4'd14;
  localparam logic [3:0] CODE_BLANK   = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } dwell_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the segment encoder: 7-bit pattern in, 4-bit code out.
// Define SEG7_READER_GLYPH_EN to also accept the U, P and L glyphs; otherwise they decode as illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] code_o
);

  always_comb begin
    code_o = CODE_ILLEGAL;
    case (pattern_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
`ifdef SEG7_READER_GLYPH_EN
      SEG_U:     code_o = CODE_U;
      SEG_P:     code_o = CODE_P;
      SEG_L:     code_o = CODE_L;
`else
      SEG_U, SEG_P, SEG_L: code_o = CODE_ILLEGAL;
`endif
      SEG_BLANK: code_o = CODE_BLANK;
      default:   code_o = CODE_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Watches a multiplexed 7-segment bus, debounces each digit dwell and hands whole frames out on valid/ready.
// Glyph decoding (U/P/L) is enabled by defining SEG7_READER_GLYPH_EN.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   frame_code,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  illegal_seen,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [6:0]          sSeg_q;
  logic [DIGITS-1:0]   sDig_q;
  logic [6:0]          pSeg_q;
  logic [DIGITS-1:0]   pDig_q;
  dwell_state_e        state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cntInc;
  logic [DIGITS-1:0]   seen_q;
  logic [DIGITS-1:0]   seen_d;
  logic [3:0]          slot_q [DIGITS];
  logic [4*DIGITS-1:0] slotFlat;
  logic [4*DIGITS-1:0] frameCode_q;
  logic                frameValid_q;
  logic                illegal_q;
  logic                overrun_q;
  logic [3:0]          capCode;
  logic                digOneHot;
  logic                sampleSame;
  logic                captureNow;
  logic                seenAll;
  logic                accept;

  // The p* copy is the previous registered sample, used to detect a steady bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sSeg_q <= '0;
      sDig_q <= '0;
      pSeg_q <= '0;
      pDig_q <= '0;
    end else begin
      sSeg_q <= seg_in;
      sDig_q <= dig_en;
      pSeg_q <= sSeg_q;
      pDig_q <= sDig_q;
    end
  end

  seg7_pattern_decode uDecode (
    .pattern_i (sSeg_q),
    .code_o    (capCode)
  );

  assign digOneHot  = $onehot(sDig_q);
  assign sampleSame = (sSeg_q == pSeg_q) && (sDig_q == pDig_q);
  assign cntInc     = cnt_q + CNT_ONE;
  assign captureNow = digOneHot && (state_q == SETTLE) && sampleSame && (cntInc == CNT_TARGET);
  assign seenAll    = &seen_q;
  assign accept     = frameValid_q && frame_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (!digOneHot) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if ((state_q == IDLE) || !sampleSame) begin
      state_q <= SETTLE;
      cnt_q   <= CNT_ONE;
    end else if (state_q == SETTLE) begin
      cnt_q <= cntInc;
      if (cntInc == CNT_TARGET) begin
        state_q <= HOLD;
      end
    end
  end

  // A completed frame clears seen; capture bits are ORed in afterwards so none is lost.
  always_comb begin
    seen_d = seenAll ? '0 : seen_q;
    if (captureNow) begin
      seen_d = seen_d | sDig_q;
    end
  end

  always_comb begin
    slotFlat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      slotFlat[4*i +: 4] = slot_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q    <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        slot_q[i] <= CODE_BLANK;
      end
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < DIGITS; i++) begin
        if (captureNow && sDig_q[i]) begin
          slot_q[i] <= capCode;
        end
      end
      if (captureNow && (capCode == CODE_ILLEGAL)) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // An acceptance in the same cycle as a completion frees the register for the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frameCode_q  <= '1;
      frameValid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (seenAll) begin
      if (!frameValid_q || accept) begin
        frameCode_q  <= slotFlat;
        frameValid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (accept) begin
      frameValid_q <= 1'b0;
    end
  end

  assign frame_code   = frameCode_q;
  assign frame_valid  = frameValid_q;
  assign illegal_seen = illegal_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (DIGITS=2, STABLE_CYCLES=4); expectations follow
// SEG7_READER_GLYPH_EN for the U glyph.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [1:0] dig_en;
  logic       frame_ready;
  logic [7:0] frame_code;
  logic       frame_valid;
  logic       illegal_seen;
  logic       overrun;

  int checkCount = 0;
  int errorCount = 0;

`ifdef SEG7_READER_GLYPH_EN
  localparam logic [3:0] EXP_U_CODE = 4'hA;
  localparam logic       EXP_U_ILL  = 1'b0;
`else
  localparam logic [3:0] EXP_U_CODE = 4'hE;
  localparam logic       EXP_U_ILL  = 1'b1;
`endif

  seg7_reader #(
    .DIGITS        (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .dig_en       (dig_en),
    .frame_code   (frame_code),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .illegal_seen (illegal_seen),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Pins change on the falling edge and are held across the given number of rising edges.
  task automatic applyStimulus(input logic [6:0] seg, input logic [1:0] dig, input int cycles);
    seg_in = seg;
    dig_en = dig;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    seg_in      = 7'b0000000;
    dig_en      = 2'b00;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_code",    32'(frame_code),   32'h0000_00FF);
    checkOutput("rst_valid",   32'(frame_valid),  32'd0);
    checkOutput("rst_illegal", 32'(illegal_seen), 32'd0);
    checkOutput("rst_overrun", 32'(overrun),      32'd0);

    $display("[TB] basic frame 3,2");
    applyStimulus(7'b1011011, 2'b01, 6);
    applyStimulus(7'b1001111, 2'b10, 6);
    checkOutput("basic_valid", 32'(frame_valid), 32'd1);
    checkOutput("basic_code",  32'(frame_code),  32'h0000_0032);
    applyStimulus(7'b0000000, 2'b00, 1);
    checkOutput("basic_drop",    32'(frame_valid),  32'd0);
    checkOutput("basic_overrun", 32'(overrun),      32'd0);
    checkOutput("basic_illegal", 32'(illegal_seen), 32'd0);

    $display("[TB] dwell length boundary");
    applyStimulus(7'b0000000, 2'b00, 2);
    applyStimulus(7'b0000111, 2'b01, 3);
    applyStimulus(7'b0000000, 2'b00, 2);
    applyStimulus(7'b0000110, 2'b10, 6);
    applyStimulus(7'b0000000, 2'b00, 2);
    checkOutput("short_dwell_valid", 32'(frame_valid), 32'd0);
    applyStimulus(7'b0000111, 2'b01, 4);
    applyStimulus(7'b0000000, 2'b00, 1);
    checkOutput("exact_dwell_early", 32'(frame_valid), 32'd0);
    applyStimulus(7'b0000000, 2'b00, 1);
    checkOutput("exact_dwell_valid", 32'(frame_valid), 32'd1);
    checkOutput("exact_dwell_code",  32'(frame_code),  32'h0000_0017);
    applyStimulus(7'b0000000, 2'b00, 1);
    checkOutput("exact_dwell_drop",  32'(frame_valid), 32'd0);

    $display("[TB] overrun with consumer stalled");
    frame_ready = 1'b0;
    applyStimulus(7'b1001111, 2'b01, 6);
    applyStimulus(7'b1100110, 2'b10, 6);
    checkOutput("ovr_first_valid", 32'(frame_valid), 32'd1);
    checkOutput("ovr_first_code",  32'(frame_code),  32'h0000_0043);
    checkOutput("ovr_not_yet",     32'(overrun),     32'd0);
    applyStimulus(7'b1101101, 2'b01, 6);
    applyStimulus(7'b1111101, 2'b10, 6);
    checkOutput("ovr_flag",      32'(overrun),     32'd1);
    checkOutput("ovr_code_held", 32'(frame_code),  32'h0000_0043);
    checkOutput("ovr_valid",     32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    applyStimulus(7'b1111101, 2'b10, 1);
    checkOutput("ovr_accept_drop", 32'(frame_valid), 32'd0);

    $display("[TB] glyph and illegal patterns");
    applyStimulus(7'b0111110, 2'b01, 6);
    checkOutput("u_glyph_illegal", 32'(illegal_seen), 32'(EXP_U_ILL));
    applyStimulus(7'b1010101, 2'b10, 6);
    checkOutput("illegal_flag",  32'(illegal_seen), 32'd1);
    checkOutput("illegal_valid", 32'(frame_valid),  32'd1);
    checkOutput("illegal_code",  32'(frame_code),   32'({4'hE, EXP_U_CODE}));
    applyStimulus(7'b0000000, 2'b00, 1);

    $display("[TB] broken dwells and blank capture");
    applyStimulus(7'b1111111, 2'b01, 2);
    applyStimulus(7'b1111111, 2'b11, 1);
    applyStimulus(7'b1111111, 2'b01, 2);
    applyStimulus(7'b1101111, 2'b01, 2);
    applyStimulus(7'b1101111, 2'b00, 1);
    applyStimulus(7'b1101111, 2'b01, 2);
    applyStimulus(7'b0000000, 2'b10, 6);
    applyStimulus(7'b0000000, 2'b00, 2);
    checkOutput("broken_no_frame", 32'(frame_valid), 32'd0);
    applyStimulus(7'b0111111, 2'b01, 6);
    checkOutput("blank_valid", 32'(frame_valid), 32'd1);
    checkOutput("blank_code",  32'(frame_code),  32'h0000_00F0);
    applyStimulus(7'b0000000, 2'b00, 1);

    $display("[TB] reset mid-dwell with frame pending");
    frame_ready = 1'b0;
    applyStimulus(7'b0000110, 2'b01, 6);
    applyStimulus(7'b1011011, 2'b10, 6);
    checkOutput("pend_valid", 32'(frame_valid), 32'd1);
    checkOutput("pend_code",  32'(frame_code),  32'h0000_0021);
    applyStimulus(7'b1001111, 2'b01, 3);
    rst_n = 1'b0;
    applyStimulus(7'b0000000, 2'b00, 1);
    rst_n = 1'b1;
    checkOutput("mid_rst_code",    32'(frame_code),   32'h0000_00FF);
    checkOutput("mid_rst_valid",   32'(frame_valid),  32'd0);
    checkOutput("mid_rst_illegal", 32'(illegal_seen), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun),      32'd0);
    applyStimulus(7'b1101101, 2'b10, 6);
    applyStimulus(7'b0000000, 2'b00, 2);
    checkOutput("post_rst_partial", 32'(frame_valid), 32'd0);
    applyStimulus(7'b1100110, 2'b01, 6);
    checkOutput("post_rst_valid", 32'(frame_valid), 32'd1);
    checkOutput("post_rst_code",  32'(frame_code),  32'h0000_0054);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
